// File: rtl/clic_pkg.sv
// clic_pkg: shared constants for the CLIC trigger gateway.
//   CLIC_TRIG_*    : attr_trig encodings, bit 0 = edge, bit 1 = negative polarity
//   trig_is_edge() : true for edge-triggered encodings
//   trig_is_neg()  : true for negative-polarity encodings
package clic_pkg;

    localparam logic [1:0] CLIC_TRIG_POS_LEVEL = 2'b00;
    localparam logic [1:0] CLIC_TRIG_POS_EDGE  = 2'b01;
    localparam logic [1:0] CLIC_TRIG_NEG_LEVEL = 2'b10;
    localparam logic [1:0] CLIC_TRIG_NEG_EDGE  = 2'b11;

    function automatic logic trig_is_edge(input logic [1:0] trig);
        return trig[0];
    endfunction

    function automatic logic trig_is_neg(input logic [1:0] trig);
        return trig[1];
    endfunction

endpackage

// File: rtl/clic_trig_cell.sv
// clic_trig_cell: trigger handling for one interrupt source.
//   clk_i, rst_ni : clock, async active-low reset
//   src_i         : raw interrupt line
//   trig_i        : attr_trig for this source
//   ip_we_i       : software write strobe to ip
//   ip_wdata_i    : software write data
//   claim_i       : this source is being claimed this cycle
//   ip_o          : pending bit
module clic_trig_cell
    import clic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       src_i,
    input  logic [1:0] trig_i,
    input  logic       ip_we_i,
    input  logic       ip_wdata_i,
    input  logic       claim_i,
    output logic       ip_o
);

    logic       src_sync;
    logic       prev_q, prev_d;
    logic [1:0] trig_q, trig_d;
    logic       ip_q, ip_d;
    logic       active, active_prev, edge_det, mode_chg;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_sync = src_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            always_comb begin
                sync_d = (sync_q << 1) | SYNC_STAGES'(src_i);
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sync_q <= '0;
                else         sync_q <= sync_d;
            end

            assign src_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // prev holds the raw synchronised value; polarity is applied on both
    // sides of the compare so a negative-edge source idling low out of
    // reset (prev=0, sync=0) does not see a phantom edge.
    always_comb begin
        active      = src_sync ^ trig_is_neg(trig_i);
        active_prev = prev_q ^ trig_is_neg(trig_i);
        mode_chg    = (trig_i != trig_q);
        edge_det    = active & ~active_prev & ~mode_chg;
        prev_d      = src_sync;
        trig_d      = trig_i;

        ip_d = ip_q;
        if (mode_chg) begin
            ip_d = 1'b0;
        end else if (!trig_is_edge(trig_i)) begin
            ip_d = active;
        end else if (edge_det) begin
            ip_d = 1'b1;          // wins over a same-cycle claim
        end else if (ip_we_i) begin
            ip_d = ip_wdata_i;
        end else if (claim_i) begin
            ip_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            trig_q <= CLIC_TRIG_POS_LEVEL;
            ip_q   <= 1'b0;
        end else begin
            prev_q <= prev_d;
            trig_q <= trig_d;
            ip_q   <= ip_d;
        end
    end

    assign ip_o = ip_q;

endmodule

// File: rtl/clic_trig_gateway.sv
// clic_trig_gateway: per-source CLIC trigger gateway owning the pending bits.
//   clk_i, rst_ni       : clock, async active-low reset
//   intr_src_i          : raw interrupt lines
//   trig_i              : 2 bits per source, source i at [2i+1:2i]
//   ip_we_i, ip_wdata_i : software writes to clicint.ip
//   claim_valid_i       : a claim happens this cycle
//   claim_id_i          : id being claimed (ids >= N_SOURCE are ignored)
//   ip_o                : pending vector (arbiter and hw2reg .d)
//   ip_de_o             : hw2reg write enable, tied high
module clic_trig_gateway
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IdWidth     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_SOURCE-1:0]   intr_src_i,
    input  logic [2*N_SOURCE-1:0] trig_i,
    input  logic [N_SOURCE-1:0]   ip_we_i,
    input  logic [N_SOURCE-1:0]   ip_wdata_i,
    input  logic                  claim_valid_i,
    input  logic [IdWidth-1:0]    claim_id_i,
    output logic [N_SOURCE-1:0]   ip_o,
    output logic [N_SOURCE-1:0]   ip_de_o
);

    logic [N_SOURCE-1:0] claim_vec;

    // Out-of-range ids match no source and so fall away naturally.
    always_comb begin
        claim_vec = '0;
        for (int unsigned i = 0; i < N_SOURCE; i++) begin
            claim_vec[i] = claim_valid_i && (64'(claim_id_i) == 64'(i));
        end
    end

    generate
        for (genvar i = 0; i < int'(N_SOURCE); i++) begin : g_cell
            clic_trig_cell #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_cell (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .src_i     (intr_src_i[i]),
                .trig_i    (trig_i[2*i +: 2]),
                .ip_we_i   (ip_we_i[i]),
                .ip_wdata_i(ip_wdata_i[i]),
                .claim_i   (claim_vec[i]),
                .ip_o      (ip_o[i])
            );
        end
    endgenerate

    assign ip_de_o = '1;

endmodule

// File: tb/tb_clic_trig_gateway.sv
module tb_clic_trig_gateway;
    import clic_pkg::*;

    localparam int unsigned N  = 32;
    localparam int unsigned IW = 6;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  intr_src_i;
    logic [2*N-1:0] trig_i;
    logic [N-1:0]  ip_we_i, ip_wdata_i;
    logic          claim_valid_i;
    logic [IW-1:0] claim_id_i;
    logic [N-1:0]  ip_o, ip_de_o;

    int checks = 0;
    int errors = 0;

    clic_trig_gateway #(.N_SOURCE(N), .SYNC_STAGES(2), .IdWidth(IW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .intr_src_i   (intr_src_i),
        .trig_i       (trig_i),
        .ip_we_i      (ip_we_i),
        .ip_wdata_i   (ip_wdata_i),
        .claim_valid_i(claim_valid_i),
        .claim_id_i   (claim_id_i),
        .ip_o         (ip_o),
        .ip_de_o      (ip_de_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; intr_src_i = '0; trig_i = '0; ip_we_i = '0; ip_wdata_i = '0;
        claim_valid_i = 1'b0; claim_id_i = '0;
        #12;
        check("reset_ip", 64'(ip_o), 64'h0);
        check("reset_de", 64'(ip_de_o), 64'hFFFF_FFFF);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(2);
        check("idle_level", 64'(ip_o), 64'h0);

        // POS_EDGE on source 3, latency SYNC_STAGES+1, then claim
        trig_i[7:6] = CLIC_TRIG_POS_EDGE;
        tick(3);
        intr_src_i[3] = 1'b1;
        tick(2);
        check("pe_lat2", 64'(ip_o[3]), 64'h0);
        tick(1);
        check("pe_lat3", 64'(ip_o[3]), 64'h1);
        claim_valid_i = 1'b1; claim_id_i = 6'd3;
        tick(1);
        claim_valid_i = 1'b0;
        check("pe_claim", 64'(ip_o[3]), 64'h0);
        tick(2);
        check("pe_claim_hold", 64'(ip_o[3]), 64'h0);

        // NEG_LEVEL on source 5
        trig_i[11:10] = CLIC_TRIG_NEG_LEVEL;
        tick(3);
        check("nl_low", 64'(ip_o[5]), 64'h1);
        claim_valid_i = 1'b1; claim_id_i = 6'd5;
        tick(1);
        claim_valid_i = 1'b0;
        check("nl_claim_ign", 64'(ip_o[5]), 64'h1);
        ip_we_i[5] = 1'b1; ip_wdata_i[5] = 1'b0;
        tick(1);
        ip_we_i[5] = 1'b0;
        check("nl_we_ign", 64'(ip_o[5]), 64'h1);
        intr_src_i[5] = 1'b1;
        tick(2);
        check("nl_lat2", 64'(ip_o[5]), 64'h1);
        tick(1);
        check("nl_lat3", 64'(ip_o[5]), 64'h0);

        // Edge and claim of the same id in the same cycle, source 7
        trig_i[15:14] = CLIC_TRIG_POS_EDGE;
        tick(3);
        intr_src_i[7] = 1'b1;
        tick(2);
        claim_valid_i = 1'b1; claim_id_i = 6'd7;
        tick(1);
        claim_valid_i = 1'b0;
        check("edge_vs_claim", 64'(ip_o[7]), 64'h1);
        ip_we_i[7] = 1'b1; ip_wdata_i[7] = 1'b0;
        tick(1);
        ip_we_i[7] = 1'b0;
        check("sw_clear", 64'(ip_o[7]), 64'h0);

        // Software set on idle POS_EDGE source 9
        trig_i[19:18] = CLIC_TRIG_POS_EDGE;
        tick(3);
        ip_we_i[9] = 1'b1; ip_wdata_i[9] = 1'b1;
        tick(1);
        ip_we_i[9] = 1'b0; ip_wdata_i[9] = 1'b0;
        check("sw_set", 64'(ip_o[9]), 64'h1);
        tick(3);
        check("sw_set_hold", 64'(ip_o[9]), 64'h1);
        claim_valid_i = 1'b1; claim_id_i = 6'd9;
        tick(1);
        claim_valid_i = 1'b0;
        check("sw_set_claim", 64'(ip_o[9]), 64'h0);

        // Mode change POS_LEVEL -> POS_EDGE with src high, source 11
        intr_src_i[11] = 1'b1;
        tick(4);
        check("mc_level", 64'(ip_o[11]), 64'h1);
        trig_i[23:22] = CLIC_TRIG_POS_EDGE;
        tick(1);
        check("mc_clear", 64'(ip_o[11]), 64'h0);
        tick(3);
        check("mc_noedge", 64'(ip_o[11]), 64'h0);
        intr_src_i[11] = 1'b0;
        tick(3);
        intr_src_i[11] = 1'b1;
        tick(2);
        check("mc_edge_lat2", 64'(ip_o[11]), 64'h0);
        tick(1);
        check("mc_edge_lat3", 64'(ip_o[11]), 64'h1);

        // All sources edge mode, all pending via software
        for (int i = 0; i < int'(N); i++) trig_i[2*i +: 2] = CLIC_TRIG_POS_EDGE;
        tick(1);
        ip_we_i = '1; ip_wdata_i = '1;
        tick(1);
        ip_we_i = '0; ip_wdata_i = '0;
        check("all_pending", 64'(ip_o), 64'hFFFF_FFFF);
        claim_valid_i = 1'b1; claim_id_i = 6'd40;
        tick(1);
        check("claim_oor", 64'(ip_o), 64'hFFFF_FFFF);
        claim_id_i = 6'd0;
        tick(1);
        claim_valid_i = 1'b0;
        check("claim_id0", 64'(ip_o), 64'hFFFF_FFFE);

        // Async reset mid-pending
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset", 64'(ip_o), 64'h0);
        intr_src_i = '0; trig_i = '0;
        trig_i[1:0] = CLIC_TRIG_NEG_EDGE;
        trig_i[3:2] = CLIC_TRIG_NEG_LEVEL;
        @(negedge clk_i);
        check("reset_hold", 64'(ip_o), 64'h0);
        rst_ni = 1'b1;
        tick(3);
        check("post_reset_neg", 64'(ip_o), 64'h2);
        tick(3);
        check("neg_edge_quiet", 64'(ip_o), 64'h2);
        intr_src_i[0] = 1'b1;
        tick(4);
        intr_src_i[0] = 1'b0;
        tick(3);
        check("neg_edge_fire", 64'(ip_o), 64'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
